// File: rtl/sobel_window_stream.sv
// Streaming 3x3 Sobel |Gx|+|Gy| over a column-major 3-row pixel strip.
// Define SOBEL_THRESHOLD_EN to binarise the magnitude against threshold_i.
module sobel_window_stream #(
  parameter int PIXEL_WIDTH = 8,
  parameter int OUT_WIDTH   = 8,
  parameter int MAX_COLS    = 640,
  parameter int CNT_W       = $clog2(MAX_COLS + 1)
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic                   start_i,
  input  logic [CNT_W-1:0]       cols_i,
  input  logic [OUT_WIDTH-1:0]   threshold_i,
  input  logic                   px_valid_i,
  output logic                   px_ready_o,
  input  logic [PIXEL_WIDTH-1:0] px_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [OUT_WIDTH-1:0]   out_data_o,
  output logic                   out_last_o,
  output logic                   busy_o,
  output logic                   err_o
);
  localparam int MAG_W = PIXEL_WIDTH + 3;
  localparam int CMP_W = (MAG_W > OUT_WIDTH) ? MAG_W : OUT_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_SLIDE, ST_DONE} state_t;

  state_t                 state_reg;
  logic [PIXEL_WIDTH-1:0] win_reg [3][3];
  logic [CNT_W-1:0]       cols_reg;
  logic [CNT_W-1:0]       win_cnt_reg;
  logic [1:0]             col_idx_reg;
  logic [1:0]             row_idx_reg;
  logic                   win_pend_reg;
  logic                   pend_last_reg;
  logic                   err_lock_reg;
  logic                   out_valid_reg;
  logic                   out_last_reg;
  logic [OUT_WIDTH-1:0]   out_data_reg;
  logic                   err_reg;

  logic                   px_accept;
  logic                   cols_legal;
  logic [CNT_W-1:0]       win_cnt_next;
  logic                   win_is_last;
  logic                   transfer;

  assign px_ready_o   = ((state_reg == ST_FILL) || (state_reg == ST_SLIDE)) && !win_pend_reg;
  assign px_accept    = px_valid_i && px_ready_o;
  assign cols_legal   = (cols_i >= CNT_W'(3)) && (cols_i <= CNT_W'(MAX_COLS));
  assign win_cnt_next = win_cnt_reg + 1'b1;
  assign win_is_last  = (win_cnt_next == (cols_reg - CNT_W'(2)));
  assign transfer     = win_pend_reg && (!out_valid_reg || out_ready_i);

  // Sobel arithmetic on zero-extended taps; the window is frozen while win_pend is set.
  logic signed [MAG_W-1:0] tap [3][3];
  for (genvar gi = 0; gi < 9; gi++) begin : g_tap
    assign tap[gi/3][gi%3] = $signed({3'b000, win_reg[gi/3][gi%3]});
  end

  logic signed [MAG_W-1:0] gx, gy, abs_gx, abs_gy;
  logic        [MAG_W-1:0] mag;
  logic    [OUT_WIDTH-1:0] result;

  assign gx = (tap[2][0] + (tap[2][1] <<< 1) + tap[2][2])
            - (tap[0][0] + (tap[0][1] <<< 1) + tap[0][2]);
  assign gy = (tap[0][2] + (tap[1][2] <<< 1) + tap[2][2])
            - (tap[0][0] + (tap[1][0] <<< 1) + tap[2][0]);
  assign abs_gx = gx[MAG_W-1] ? -gx : gx;
  assign abs_gy = gy[MAG_W-1] ? -gy : gy;
  assign mag    = $unsigned(abs_gx) + $unsigned(abs_gy);

`ifdef SOBEL_THRESHOLD_EN
  assign result = (CMP_W'(mag) >= CMP_W'(threshold_i)) ? '1 : '0;
`else
  if (OUT_WIDTH >= MAG_W) begin : g_nosat
    assign result = OUT_WIDTH'(mag);
  end else begin : g_sat
    assign result = (|mag[MAG_W-1:OUT_WIDTH]) ? '1 : mag[OUT_WIDTH-1:0];
  end
  logic unused_threshold;
  assign unused_threshold = &{1'b0, threshold_i};
`endif

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_reg     <= ST_IDLE;
      cols_reg      <= '0;
      win_cnt_reg   <= '0;
      col_idx_reg   <= '0;
      row_idx_reg   <= '0;
      win_pend_reg  <= 1'b0;
      pend_last_reg <= 1'b0;
      err_lock_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      err_reg       <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        for (int r = 0; r < 3; r++) begin
          win_reg[c][r] <= '0;
        end
      end
    end else begin
      err_reg <= 1'b0;
      if (!start_i) begin
        err_lock_reg <= 1'b0;
      end

      // Output stage: refill the register in the same cycle it is consumed.
      if (transfer) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= result;
        out_last_reg  <= pend_last_reg;
        win_pend_reg  <= 1'b0;
      end else if (out_ready_i) begin
        out_valid_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (start_i && !err_lock_reg) begin
            if (cols_legal) begin
              state_reg   <= ST_FILL;
              cols_reg    <= cols_i;
              win_cnt_reg <= '0;
              col_idx_reg <= '0;
              row_idx_reg <= '0;
            end else begin
              err_reg      <= 1'b1;
              err_lock_reg <= 1'b1;
            end
          end
        end

        ST_FILL, ST_SLIDE: begin
          if (!start_i) begin
            state_reg     <= ST_IDLE;
            win_cnt_reg   <= '0;
            col_idx_reg   <= '0;
            row_idx_reg   <= '0;
            pend_last_reg <= 1'b0;
          end else if (px_accept) begin
            if (state_reg == ST_FILL) begin
              win_reg[col_idx_reg][row_idx_reg] <= px_data_i;
            end else if (row_idx_reg == 2'd0) begin
              for (int c = 0; c < 2; c++) begin
                for (int r = 0; r < 3; r++) begin
                  win_reg[c][r] <= win_reg[c+1][r];
                end
              end
              win_reg[2][0] <= px_data_i;
            end else begin
              win_reg[2][row_idx_reg] <= px_data_i;
            end

            if (row_idx_reg == 2'd2) begin
              row_idx_reg <= '0;
              if (state_reg == ST_FILL) begin
                col_idx_reg <= col_idx_reg + 2'd1;
              end
              if ((state_reg == ST_SLIDE) || (col_idx_reg == 2'd2)) begin
                win_pend_reg  <= 1'b1;
                pend_last_reg <= win_is_last;
                win_cnt_reg   <= win_cnt_next;
                state_reg     <= win_is_last ? ST_DONE : ST_SLIDE;
              end
            end else begin
              row_idx_reg <= row_idx_reg + 2'd1;
            end
          end
        end

        ST_DONE: begin
          if (!win_pend_reg && !start_i) begin
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign out_valid_o = out_valid_reg;
  assign out_data_o  = out_data_reg;
  assign out_last_o  = out_last_reg;
  assign busy_o      = (state_reg != ST_IDLE);
  assign err_o       = err_reg;

endmodule

// File: tb/tb_sobel_window_stream.sv
// Self-checking bench for sobel_window_stream: random strips vs. an arithmetic Sobel model.
module tb_sobel_window_stream;
  localparam int PW   = 8;
  localparam int OW   = 8;
  localparam int MAXC = 640;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int TBC  = 64;

  logic          clk_i = 1'b0;
  logic          nreset_i;
  logic          start_i;
  logic [CW-1:0] cols_i;
  logic [OW-1:0] threshold_i;
  logic          px_valid_i;
  logic          px_ready_o;
  logic [PW-1:0] px_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [OW-1:0] out_data_o;
  logic          out_last_o;
  logic          busy_o;
  logic          err_o;

  sobel_window_stream #(
    .PIXEL_WIDTH(PW), .OUT_WIDTH(OW), .MAX_COLS(MAXC)
  ) dut (
    .clk_i(clk_i), .nreset_i(nreset_i), .start_i(start_i), .cols_i(cols_i),
    .threshold_i(threshold_i), .px_valid_i(px_valid_i), .px_ready_o(px_ready_o),
    .px_data_i(px_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  logic [PW-1:0] pix [0:3*TBC-1];
  logic [OW-1:0] obs_data [$];
  logic          obs_last [$];
  int            obs_cyc  [$];
  int            hold_viol;
  int            n_checks = 0;
  int            n_bad    = 0;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Reference: window k covers strip columns k..k+2, pixel (col,row) at pix[col*3+row].
  function automatic int exp_result(input int k);
    int w [3][3];
    int gx, gy, mag;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        w[c][r] = int'(pix[(k + c) * 3 + r]);
    gx  = (w[2][0] + 2 * w[2][1] + w[2][2]) - (w[0][0] + 2 * w[0][1] + w[0][2]);
    gy  = (w[0][2] + 2 * w[1][2] + w[2][2]) - (w[0][0] + 2 * w[1][0] + w[2][0]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESHOLD_EN
    return (mag >= int'(threshold_i)) ? 255 : 0;
`else
    return (mag > 255) ? 255 : mag;
`endif
  endfunction

  task automatic fill_random(input int ncols);
    for (int i = 0; i < 3 * ncols; i++) pix[i] = PW'($urandom_range(0, 255));
  endtask

  // Streams pix[0..3*ncols-1] with random valid/ready; collects every output transfer.
  task automatic run_strip(input int ncols, input int vld_pct, input int rdy_pct,
                           input int stall_at, input int stall_len, output bit timed_out);
    int idx = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [OW-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    obs_data.delete(); obs_last.delete(); obs_cyc.delete();
    hold_viol = 0;
    timed_out = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1;
    cols_i  = CW'(ncols);
    while ((obs_data.size() < ncols - 2) || (idx < 3 * ncols)) begin
      @(negedge clk_i);
      cyc++;
      if (cyc > 3000) begin
        timed_out = 1'b1;
        break;
      end
      if (prev_stall && (out_valid_o !== 1'b1 || out_data_o !== prev_data || out_last_o !== prev_last))
        hold_viol++;
      px_valid_i  = (idx < 3 * ncols) && ($urandom_range(0, 99) < vld_pct);
      px_data_i   = (idx < 3 * ncols) ? pix[idx] : '0;
      out_ready_i = ($urandom_range(0, 99) < rdy_pct) &&
                    !((cyc >= stall_at) && (cyc < stall_at + stall_len));
      if (px_valid_i && px_ready_o) idx++;
      if (out_valid_o && out_ready_i) begin
        obs_data.push_back(out_data_o);
        obs_last.push_back(out_last_o);
        obs_cyc.push_back(cyc);
        $display("  cols=%0d result %0d: data=%0d last=%0b", ncols, obs_data.size() - 1,
                 out_data_o, out_last_o);
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_data  = out_data_o;
      prev_last  = out_last_o;
    end
    px_valid_i  = 1'b0;
    start_i     = 1'b0;
    out_ready_i = 1'b1;
    cyc = 0;
    while (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      @(negedge clk_i);
      cyc++;
      if (cyc > 50) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    nreset_i = 1'b0; start_i = 1'b0; cols_i = '0; threshold_i = 8'd128;
    px_valid_i = 1'b0; px_data_i = '0; out_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    n_checks++; if (px_ready_o !== 1'b0)  begin n_bad++; $display("FAIL reset_px_ready: got %b want 0", px_ready_o); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
    n_checks++; if (out_data_o !== '0)    begin n_bad++; $display("FAIL reset_out_data: got %0d want 0", out_data_o); end
    n_checks++; if (out_last_o !== 1'b0)  begin n_bad++; $display("FAIL reset_out_last: got %b want 0", out_last_o); end
    n_checks++; if (busy_o !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_checks++; if (err_o !== 1'b0)       begin n_bad++; $display("FAIL reset_err: got %b want 0", err_o); end
    nreset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_checks++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy: got %b want 0", busy_o); end
    $display("test_reset done");
  endtask

  task automatic test_flat();
    bit to;
    for (int i = 0; i < 15; i++) pix[i] = 8'd100;
    run_strip(5, 100, 100, 0, 0, to);
    n_checks++; if (to !== 1'b0) begin n_bad++; $display("FAIL flat_timeout: got %b want 0", to); end
    n_checks++; if (obs_data.size() != 3) begin n_bad++; $display("FAIL flat_count: got %0d want 3", obs_data.size()); end
    for (int k = 0; k < obs_data.size() && k < 3; k++) begin
      n_checks++;
      if (obs_data[k] !== 8'd0) begin n_bad++; $display("FAIL flat_data[%0d]: got %0d want 0", k, obs_data[k]); end
      n_checks++;
      if (obs_last[k] !== (k == 2)) begin n_bad++; $display("FAIL flat_last[%0d]: got %b want %b", k, obs_last[k], k == 2); end
    end
    $display("test_flat done");
  endtask

  task automatic test_vertical_edge();
    int idx = 0;
    int cyc = 0;
    for (int i = 0; i < 9; i++) pix[i] = (i >= 6) ? 8'd255 : 8'd0;
    @(negedge clk_i);
    start_i = 1'b1; cols_i = CW'(3); out_ready_i = 1'b1;
    while (idx < 9 && cyc < 50) begin
      @(negedge clk_i);
      cyc++;
      px_valid_i = 1'b1;
      px_data_i  = pix[idx];
      if (px_ready_o) idx++;
    end
    n_checks++; if (idx != 9) begin n_bad++; $display("FAIL edge_accept: got %0d pixels want 9", idx); end
    @(negedge clk_i);
    px_valid_i = 1'b0;
    n_checks++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL edge_latency_early: got out_valid=%b want 0", out_valid_o); end
    n_checks++; if (px_ready_o !== 1'b0)  begin n_bad++; $display("FAIL edge_pend_ready: got %b want 0", px_ready_o); end
    @(negedge clk_i);
    n_checks++; if (out_valid_o !== 1'b1) begin n_bad++; $display("FAIL edge_latency: got out_valid=%b want 1", out_valid_o); end
    n_checks++; if (int'(out_data_o) !== exp_result(0)) begin n_bad++; $display("FAIL edge_data: got %0d want %0d", out_data_o, exp_result(0)); end
    n_checks++; if (out_last_o !== 1'b1)  begin n_bad++; $display("FAIL edge_last: got %b want 1", out_last_o); end
    $display("  cols=3 result 0: data=%0d last=%0b", out_data_o, out_last_o);
    @(negedge clk_i);
    n_checks++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL edge_consumed: got %b want 0", out_valid_o); end
    start_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL edge_idle: got busy=%b want 0", busy_o); end
    $display("test_vertical_edge done");
  endtask

  task automatic test_backpressure();
    bit to;
    fill_random(6);
    run_strip(6, 100, 100, 8, 20, to);
    n_checks++; if (to !== 1'b0) begin n_bad++; $display("FAIL bp_timeout: got %b want 0", to); end
    n_checks++; if (obs_data.size() != 4) begin n_bad++; $display("FAIL bp_count: got %0d want 4", obs_data.size()); end
    n_checks++; if (hold_viol != 0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_viol); end
    for (int k = 0; k < obs_data.size() && k < 4; k++) begin
      n_checks++;
      if (int'(obs_data[k]) !== exp_result(k)) begin n_bad++; $display("FAIL bp_data[%0d]: got %0d want %0d", k, obs_data[k], exp_result(k)); end
      n_checks++;
      if (obs_last[k] !== (k == 3)) begin n_bad++; $display("FAIL bp_last[%0d]: got %b want %b", k, obs_last[k], k == 3); end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_back_to_back();
    bit to;
    fill_random(8);
    run_strip(8, 100, 100, 0, 0, to);
    n_checks++; if (to !== 1'b0) begin n_bad++; $display("FAIL b2b_timeout: got %b want 0", to); end
    n_checks++; if (obs_data.size() != 6) begin n_bad++; $display("FAIL b2b_count: got %0d want 6", obs_data.size()); end
    for (int k = 0; k < obs_data.size() && k < 6; k++) begin
      n_checks++;
      if (int'(obs_data[k]) !== exp_result(k)) begin n_bad++; $display("FAIL b2b_data[%0d]: got %0d want %0d", k, obs_data[k], exp_result(k)); end
      if (k > 0) begin
        n_checks++;
        if (obs_cyc[k] - obs_cyc[k-1] != 4) begin n_bad++; $display("FAIL b2b_spacing[%0d]: got %0d cycles want 4", k, obs_cyc[k] - obs_cyc[k-1]); end
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_abort();
    int idx = 0;
    int cyc = 0;
    int vseen = 0;
    bit to;
    fill_random(5);
    @(negedge clk_i);
    start_i = 1'b1; cols_i = CW'(5); out_ready_i = 1'b1;
    while (idx < 5 && cyc < 50) begin
      @(negedge clk_i);
      cyc++;
      px_valid_i = 1'b1;
      px_data_i  = pix[idx];
      if (px_ready_o) idx++;
    end
    @(negedge clk_i);
    start_i = 1'b0; px_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (busy_o !== 1'b0)     begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy_o); end
    n_checks++; if (px_ready_o !== 1'b0) begin n_bad++; $display("FAIL abort_ready: got %b want 0", px_ready_o); end
    repeat (6) begin
      @(negedge clk_i);
      if (out_valid_o !== 1'b0) vseen++;
    end
    n_checks++; if (vseen != 0) begin n_bad++; $display("FAIL abort_output: got %0d valid cycles want 0", vseen); end
    fill_random(3);
    run_strip(3, 100, 100, 0, 0, to);
    n_checks++; if (to !== 1'b0) begin n_bad++; $display("FAIL restart_timeout: got %b want 0", to); end
    n_checks++; if (obs_data.size() != 1) begin n_bad++; $display("FAIL restart_count: got %0d want 1", obs_data.size()); end
    if (obs_data.size() > 0) begin
      n_checks++; if (int'(obs_data[0]) !== exp_result(0)) begin n_bad++; $display("FAIL restart_data: got %0d want %0d", obs_data[0], exp_result(0)); end
      n_checks++; if (obs_last[0] !== 1'b1) begin n_bad++; $display("FAIL restart_last: got %b want 1", obs_last[0]); end
    end
    $display("test_abort done");
  endtask

  task automatic test_bad_cols();
    int bad_vals [2] = '{2, MAXC + 1};
    for (int v = 0; v < 2; v++) begin
      int errs = 0;
      bit busy_seen = 1'b0;
      bit rdy_seen = 1'b0;
      @(negedge clk_i);
      start_i = 1'b1; cols_i = CW'(bad_vals[v]);
      repeat (10) begin
        @(negedge clk_i);
        if (err_o === 1'b1) errs++;
        busy_seen |= (busy_o !== 1'b0);
        rdy_seen  |= (px_ready_o !== 1'b0);
      end
      start_i = 1'b0;
      repeat (2) @(negedge clk_i);
      $display("  cols=%0d: err pulses=%0d", bad_vals[v], errs);
      n_checks++; if (errs != 1)          begin n_bad++; $display("FAIL badcols_err[%0d]: got %0d pulses want 1", bad_vals[v], errs); end
      n_checks++; if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL badcols_busy[%0d]: got %b want 0", bad_vals[v], busy_seen); end
      n_checks++; if (rdy_seen !== 1'b0)  begin n_bad++; $display("FAIL badcols_ready[%0d]: got %b want 0", bad_vals[v], rdy_seen); end
    end
    $display("test_bad_cols done");
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    int cyc = 0;
    bit to;
    fill_random(4);
    @(negedge clk_i);
    start_i = 1'b1; cols_i = CW'(4); out_ready_i = 1'b0;
    while (out_valid_o !== 1'b1 && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      px_valid_i = (idx < 12);
      px_data_i  = (idx < 12) ? pix[idx] : '0;
      if (px_valid_i && px_ready_o) idx++;
    end
    n_checks++; if (out_valid_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_valid: got %b want 1", out_valid_o); end
    nreset_i = 1'b0;
    #1;
    n_checks++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid_o); end
    n_checks++; if (out_data_o !== '0)    begin n_bad++; $display("FAIL rstmid_out_data: got %0d want 0", out_data_o); end
    n_checks++; if (out_last_o !== 1'b0)  begin n_bad++; $display("FAIL rstmid_out_last: got %b want 0", out_last_o); end
    n_checks++; if (busy_o !== 1'b0)      begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
    n_checks++; if (px_ready_o !== 1'b0)  begin n_bad++; $display("FAIL rstmid_px_ready: got %b want 0", px_ready_o); end
    n_checks++; if (err_o !== 1'b0)       begin n_bad++; $display("FAIL rstmid_err: got %b want 0", err_o); end
    px_valid_i = 1'b0; start_i = 1'b0; out_ready_i = 1'b1;
    @(negedge clk_i);
    nreset_i = 1'b1;
    @(negedge clk_i);
    fill_random(4);
    run_strip(4, 80, 70, 0, 0, to);
    n_checks++; if (to !== 1'b0) begin n_bad++; $display("FAIL rstmid_timeout: got %b want 0", to); end
    n_checks++; if (obs_data.size() != 2) begin n_bad++; $display("FAIL rstmid_count: got %0d want 2", obs_data.size()); end
    for (int k = 0; k < obs_data.size() && k < 2; k++) begin
      n_checks++;
      if (int'(obs_data[k]) !== exp_result(k)) begin n_bad++; $display("FAIL rstmid_data[%0d]: got %0d want %0d", k, obs_data[k], exp_result(k)); end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    for (int s = 0; s < 6; s++) begin
      int ncols = $urandom_range(3, 12);
      int vp = $urandom_range(50, 100);
      int rp = $urandom_range(30, 100);
      bit to;
      fill_random(ncols);
      run_strip(ncols, vp, rp, 0, 0, to);
      n_checks++; if (to !== 1'b0) begin n_bad++; $display("FAIL rand%0d_timeout: got %b want 0", s, to); end
      n_checks++; if (obs_data.size() != ncols - 2) begin n_bad++; $display("FAIL rand%0d_count: got %0d want %0d", s, obs_data.size(), ncols - 2); end
      n_checks++; if (hold_viol != 0) begin n_bad++; $display("FAIL rand%0d_hold: got %0d want 0", s, hold_viol); end
      for (int k = 0; k < obs_data.size() && k < ncols - 2; k++) begin
        n_checks++;
        if (int'(obs_data[k]) !== exp_result(k)) begin n_bad++; $display("FAIL rand%0d_data[%0d]: got %0d want %0d", s, k, obs_data[k], exp_result(k)); end
        n_checks++;
        if (obs_last[k] !== (k == ncols - 3)) begin n_bad++; $display("FAIL rand%0d_last[%0d]: got %b want %b", s, k, obs_last[k], k == ncols - 3); end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_flat();
    test_vertical_edge();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_bad_cols();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
